// File: rtl/hs_npu_pkg.sv
// Shared types for the NPU result path: the common unsigned word and the
// result-writer state encoding.
package hs_npu_pkg;

   typedef logic [31:0] uword;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ROW,
      WRITE,
      DONE
   } writer_state_e;

endpackage

// File: rtl/hs_npu_row_serializer.sv
// Row register plus beat index: captures one full result row and presents it
// as consecutive bus-width beats, lowest element in the lowest bits.
module hs_npu_row_serializer #(
   parameter int unsigned SIZE       = 8,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned BUS_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] row [SIZE],
   input  logic                  advance,
   output logic [BUS_WIDTH-1:0]  beat_data,
   output logic                  last_beat
);

   localparam int unsigned BEATS = SIZE * DATA_WIDTH / BUS_WIDTH;
   localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [SIZE*DATA_WIDTH-1:0] row_q;
   logic [IDX_W-1:0]           beat_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q  <= '0;
         beat_q <= '0;
      end else if (clear) begin
         row_q  <= '0;
         beat_q <= '0;
      end else if (load) begin
         for (int unsigned i = 0; i < SIZE; i++)
            row_q[i*DATA_WIDTH +: DATA_WIDTH] <= row[i];
         beat_q <= '0;
      end else if (advance) begin
         beat_q <= last_beat ? '0 : beat_q + 1'b1;
      end
   end

   assign last_beat = (beat_q == IDX_W'(BEATS - 1));
   assign beat_data = row_q[beat_q*BUS_WIDTH +: BUS_WIDTH];

endmodule

// File: rtl/hs_npu_result_writer.sv
// Drains SIZE output FIFOs one full row at a time and writes each row to memory
// as bus-width beats. Optional stall counter: HS_NPU_WRITER_STALL_CNT_EN.
module hs_npu_result_writer
   import hs_npu_pkg::*;
#(
   parameter int unsigned SIZE       = 8,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned BUS_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  uword                  num_rows_i,
   input  logic [DATA_WIDTH-1:0] result_i [SIZE],
   input  logic                  result_valid_i [SIZE],
   output logic                  result_ready_o,
   output logic                  mem_valid_o,
   input  logic                  mem_ready_i,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [BUS_WIDTH-1:0]  mem_data_o,
   output logic                  busy_o,
   output logic                  done_o
`ifdef HS_NPU_WRITER_STALL_CNT_EN
   ,
   output uword                  stall_cycles_o
`endif
);

   localparam int unsigned EPB   = BUS_WIDTH / DATA_WIDTH;
   localparam int unsigned BEATS = SIZE / EPB;
   localparam int unsigned BYTES = BUS_WIDTH / 8;

   writer_state_e         state, state_next;
   logic [ADDR_WIDTH-1:0] addr_q;
   uword                  num_rows_q;
   uword                  row_cnt_q;
   logic                  all_valid;
   logic                  start_ok;
   logic                  accept;
   logic                  last_beat;

   always_comb begin
      all_valid = 1'b1;
      for (int unsigned i = 0; i < SIZE; i++)
         all_valid &= result_valid_i[i];
   end

   assign start_ok = (state == IDLE) && start_i;
   assign accept   = mem_valid_o && mem_ready_i;

   always_comb begin
      state_next     = state;
      result_ready_o = 1'b0;
      mem_valid_o    = 1'b0;
      busy_o         = 1'b0;
      done_o         = 1'b0;
      case (state)
         IDLE: begin
            if (start_i)
               state_next = (num_rows_i == '0) ? DONE : WAIT_ROW;
         end
         WAIT_ROW: begin
            busy_o = 1'b1;
            if (all_valid) begin
               result_ready_o = 1'b1;
               state_next     = WRITE;
            end
         end
         WRITE: begin
            busy_o      = 1'b1;
            mem_valid_o = 1'b1;
            if (mem_ready_i && last_beat)
               state_next = (uword'(row_cnt_q + 1'b1) == num_rows_q) ? DONE : WAIT_ROW;
         end
         DONE: begin
            done_o     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A single running address replaces base + (row*BEATS + k)*BYTES since beats are contiguous.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         addr_q     <= '0;
         num_rows_q <= '0;
         row_cnt_q  <= '0;
      end else begin
         state <= state_next;
         if (start_ok) begin
            addr_q     <= base_addr_i;
            num_rows_q <= num_rows_i;
            row_cnt_q  <= '0;
         end else if (accept) begin
            addr_q <= addr_q + ADDR_WIDTH'(BYTES);
            if (last_beat)
               row_cnt_q <= row_cnt_q + 1'b1;
         end
      end
   end

   assign mem_addr_o = addr_q;

   hs_npu_row_serializer #(
      .SIZE      (SIZE),
      .DATA_WIDTH(DATA_WIDTH),
      .BUS_WIDTH (BUS_WIDTH)
   ) u_serializer (
      .clk      (clk),
      .rst      (rst),
      .clear    (start_ok),
      .load     (result_ready_o),
      .row      (result_i),
      .advance  (accept),
      .beat_data(mem_data_o),
      .last_beat(last_beat)
   );

`ifdef HS_NPU_WRITER_STALL_CNT_EN
   uword stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_q <= '0;
      else if (start_ok)
         stall_q <= '0;
      else if (mem_valid_o && !mem_ready_i && (stall_q != '1))
         stall_q <= stall_q + 1'b1;
   end

   assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_hs_npu_result_writer.sv
// Randomized bench for hs_npu_result_writer: a row/beat-count reference model
// predicts pops, beats, addresses, data and completion every cycle.
module tb_hs_npu_result_writer;

   localparam int unsigned SIZE  = 8;
   localparam int unsigned DW    = 16;
   localparam int unsigned BW    = 32;
   localparam int unsigned AW    = 32;
   localparam int unsigned EPB   = BW / DW;
   localparam int unsigned BEATS = SIZE * DW / BW;
   localparam int unsigned BYTES = BW / 8;
   localparam int unsigned MAXR  = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic [AW-1:0] base_addr_i;
   logic [31:0]   num_rows_i;
   logic [DW-1:0] result_i [SIZE];
   logic          result_valid_i [SIZE];
   logic          result_ready_o;
   logic          mem_valid_o;
   logic          mem_ready_i;
   logic [AW-1:0] mem_addr_o;
   logic [BW-1:0] mem_data_o;
   logic          busy_o;
   logic          done_o;
`ifdef HS_NPU_WRITER_STALL_CNT_EN
   logic [31:0]   stall_cycles_o;
`endif

   hs_npu_result_writer #(
      .SIZE      (SIZE),
      .DATA_WIDTH(DW),
      .BUS_WIDTH (BW),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .base_addr_i   (base_addr_i),
      .num_rows_i    (num_rows_i),
      .result_i      (result_i),
      .result_valid_i(result_valid_i),
      .result_ready_o(result_ready_o),
      .mem_valid_o   (mem_valid_o),
      .mem_ready_i   (mem_ready_i),
      .mem_addr_o    (mem_addr_o),
      .mem_data_o    (mem_data_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
`ifdef HS_NPU_WRITER_STALL_CNT_EN
      ,
      .stall_cycles_o(stall_cycles_o)
`endif
   );

   always #5 clk = ~clk;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [DW-1:0] elems [MAXR][SIZE];
   int            first_pop;
   int            job_stalls;
   logic [BW-1:0] first_data;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Beat k of row r packs elements k*EPB.. with the lowest index in the lowest bits.
   function automatic logic [BW-1:0] exp_data(input int unsigned r, input int unsigned k);
      logic [BW-1:0] d;
      d = '0;
      for (int unsigned e = 0; e < EPB; e++)
         d |= BW'(elems[r][k*EPB+e]) << (e*DW);
      return d;
   endfunction

   function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int unsigned n);
      return base + AW'(n * BYTES);
   endfunction

   // mode bits: [0] counting data, [1] column 7 late by 5 cycles,
   // [2] 3-cycle stall on beat 2, [3] spurious starts while busy
   task automatic run_job(input logic [AW-1:0] base, input int unsigned rows,
                          input int unsigned rdy_pct, input int unsigned vld_pct,
                          input int unsigned mode, input int abort_beat);
      int unsigned p, b, st_run, pops;
      bit          done_due, done_seen, aborted, allv, exp_rr, exp_mv;
      for (int unsigned r = 0; r < MAXR; r++)
         for (int unsigned c = 0; c < SIZE; c++)
            elems[r][c] = mode[0] ? DW'(r*SIZE + c) : DW'($urandom);
      @(negedge clk);
      start_i     = 1'b1;
      base_addr_i = base;
      num_rows_i  = rows;
      for (int unsigned c = 0; c < SIZE; c++) result_valid_i[c] = 1'b0;
      mem_ready_i = 1'b1;
      #2;
      check("idle_busy", busy_o, 0);
      check("idle_mem_valid", mem_valid_o, 0);
      @(negedge clk);
      start_i = 1'b0;
      p = 0; b = 0; st_run = 0; pops = 0;
      done_due = (rows == 0); done_seen = 0; aborted = 0;
      first_pop = -1; job_stalls = 0;
      for (int cyc = 0; cyc < 2000 && !done_seen; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (abort_beat >= 0 && b == abort_beat) begin
            #2;
            check("pre_abort_mem_valid", mem_valid_o, 1);
            rst = 1'b1;
            #1;
            check("abort_busy", busy_o, 0);
            check("abort_mem_valid", mem_valid_o, 0);
            aborted = 1;
            break;
         end
         for (int unsigned c = 0; c < SIZE; c++) begin
            result_valid_i[c] = ($urandom_range(99) < vld_pct);
            if (mode[1] && c == SIZE - 1 && cyc < 5) result_valid_i[c] = 1'b0;
            result_i[c] = (p < rows) ? elems[p][c] : DW'($urandom);
         end
         if (mode[2]) mem_ready_i = !(b == 2 && st_run < 3);
         else         mem_ready_i = ($urandom_range(99) < rdy_pct);
         start_i = mode[3] && ($urandom_range(3) == 0);
         if (start_i) begin
            base_addr_i = $urandom;
            num_rows_i  = $urandom_range(9);
         end
         #2;
         allv = 1;
         for (int unsigned c = 0; c < SIZE; c++) allv &= result_valid_i[c];
         exp_rr = allv && (p < rows) && (b == p*BEATS);
         exp_mv = (b < p*BEATS);
         check("result_ready", result_ready_o, exp_rr);
         check("mem_valid", mem_valid_o, exp_mv);
         check("done", done_o, done_due);
         check("busy", busy_o, !done_due);
         if (exp_mv && mem_valid_o) begin
            check("mem_addr", mem_addr_o, exp_addr(base, b));
            check("mem_data", mem_data_o, exp_data(b / BEATS, b % BEATS));
         end
         if (result_ready_o) pops++;
         if (done_due) done_seen = 1;
         if (exp_mv) begin
            if (mem_ready_i) begin
               if (b == 0) first_data = mem_data_o;
               b++;
               if (b == rows*BEATS) done_due = 1;
            end else begin
               job_stalls++;
               if (b == 2) st_run++;
            end
         end
         if (exp_rr) begin
            if (p == 0) first_pop = cyc;
            p++;
         end
      end
      if (!aborted) begin
         if (!done_seen) check("job_timeout", 0, 1);
         check("pop_count", pops, rows);
`ifdef HS_NPU_WRITER_STALL_CNT_EN
         check("stall_cycles", stall_cycles_o, job_stalls);
`endif
      end
      @(negedge clk);
      start_i = 1'b0;
      for (int unsigned c = 0; c < SIZE; c++) result_valid_i[c] = 1'b0;
      #2;
      if (!aborted) begin
         check("done_one_cycle", done_o, 0);
         check("idle_after_done", busy_o, 0);
      end
   endtask

   initial begin
      rst         = 1'b1;
      start_i     = 1'b0;
      base_addr_i = '0;
      num_rows_i  = '0;
      mem_ready_i = 1'b0;
      for (int unsigned c = 0; c < SIZE; c++) begin
         result_i[c]       = '0;
         result_valid_i[c] = 1'b0;
      end
      #12;
      check("rst_result_ready", result_ready_o, 0);
      check("rst_mem_valid", mem_valid_o, 0);
      check("rst_mem_addr", mem_addr_o, 0);
      check("rst_mem_data", mem_data_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      @(negedge clk);
      rst = 1'b0;

      run_job(32'h0000_1000, 2, 100, 100, 1, -1);
      check("first_beat_data", first_data, 32'h0001_0000);

      run_job(32'h0000_2000, 1, 100, 100, 1 | 2, -1);
      check("partial_pop_cycle", first_pop, 5);

      run_job(32'h0000_3000, 1, 100, 100, 1 | 4, -1);
      check("backpressure_stalls", job_stalls, 3);

      run_job(32'h0000_4000, 0, 100, 100, 0, -1);

      run_job(32'hFFFF_FFF8, 1, 100, 100, 0, -1);

      run_job(32'h0000_5000, 2, 100, 100, 0, 1);
      @(negedge clk);
      rst = 1'b0;
      run_job(32'h0000_6000, 3, 70, 80, 8, -1);

      repeat (8)
         run_job($urandom, $urandom_range(MAXR), $urandom_range(100, 30),
                 $urandom_range(100, 40), 8, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
